// File: rtl/pipeline_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl_pkg
// Shared definitions for the pipeline hazard controller: the data-cache miss
// FSM state encoding and the operand forward-select codes driven on
// forwardA_E / forwardB_E.
// No ports (package).
// ---------------------------------------------------------------------------
package pipeline_hazard_ctrl_pkg;

   // Miss-freeze FSM states
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MISS   = 2'd1,
      RESUME = 2'd2
   } miss_state_e;

   // Forward-select encodings for the EX-stage operand muxes
   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/pipeline_hazard_ctrl_miss_stall_fsm.sv
// ---------------------------------------------------------------------------
// miss_stall_fsm
// Data-cache miss freeze controller. A load/store in MEM that misses raises
// freeze in the same cycle, then the FSM sits in MISS for up to MISS_LAT
// cycles (fewer if refill_done arrives), followed by a single RESUME cycle in
// which the MEM instruction retires regardless of the hit input.
//
// Optional feature: HAZARD_PERF_EN exposes miss_start (IDLE->MISS entry)
// for the miss performance counter in the parent.
//
// Ports:
//   clk         in   clock
//   rst         in   asynchronous active-low reset
//   mem_access  in   load/store present in MEM
//   hit         in   cache hit for the MEM access
//   refill_done in   early refill completion (honoured only in MISS)
//   freeze      out  whole-pipeline freeze
//   miss_busy   out  FSM is in MISS or RESUME
//   miss_start  out  (HAZARD_PERF_EN only) miss detected in IDLE this cycle
// ---------------------------------------------------------------------------
module miss_stall_fsm
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int MISS_LAT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic mem_access,
   input  logic hit,
   input  logic refill_done,
   output logic freeze,
   output logic miss_busy
`ifdef HAZARD_PERF_EN
  ,output logic miss_start
`endif
);

   // Counter only has to hold MISS_LAT-1
   localparam int CNT_BITS = (MISS_LAT > 1) ? $clog2(MISS_LAT) : 1;
   localparam logic [CNT_BITS-1:0] LOAD_VAL = CNT_BITS'(MISS_LAT - 1);

   miss_state_e         state;
   logic [CNT_BITS-1:0] count;
   logic                miss_entry;

   // A new miss is only recognised from IDLE, so the RESUME cycle never
   // re-freezes on the still-present hit=0 of the retiring instruction.
   // Everything is gated by rst so the outputs are quiet while reset is held.
   always_comb begin
      miss_entry = rst && (state == IDLE) && mem_access && !hit;
      freeze     = miss_entry || (rst && (state == MISS));
      miss_busy  = rst && ((state == MISS) || (state == RESUME));
   end

`ifdef HAZARD_PERF_EN
   assign miss_start = miss_entry;
`endif

   // MISS lasts count+1 cycles, i.e. MISS_LAT cycles after the detect
   // cycle, unless refill_done cuts it short. Reset abandons a miss outright.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (mem_access && !hit) begin
                  count <= LOAD_VAL;
                  state <= MISS;
               end
            end
            MISS: begin
               if ((count == '0) || refill_done) begin
                  count <= '0;
                  state <= RESUME;
               end else begin
                  count <= count - 1'b1;
               end
            end
            RESUME: begin
               state <= IDLE;
            end
            default: begin
               count <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Hazard unit for a 5-stage pipeline: EX operand forwarding (MEM over WB,
// x0 never forwarded), load-use stall, taken-branch flush, and the data-cache
// miss freeze (in miss_stall_fsm). A freeze suppresses stall/flush outputs;
// the frozen pipeline holds branch/load-use inputs so they act afterwards.
//
// Optional feature: define HAZARD_PERF_EN to add saturating performance
// counters stall_cnt, flush_cnt and miss_cnt.
//
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   Rs1_D, Rs2_D                decode-stage source indices
//   Rs1_E, Rs2_E, Rd_E          execute-stage source/destination indices
//   Rd_M, Rd_W                  MEM / WB destination indices
//   RegWrite_M, RegWrite_W      MEM / WB register write enables
//   MemRead_E                   load in EX
//   branch                      taken redirect in EX
//   mem_access_M, hit           MEM load/store and its cache hit
//   refill_done                 early refill completion
//   forwardA_E, forwardB_E      operand forward selects (see package)
//   stall_F, stall_D            fetch/decode stall
//   flush_D, flush_E            decode/execute flush
//   freeze, miss_busy           miss freeze, miss FSM active
//   stall_cnt, flush_cnt,       (HAZARD_PERF_EN only) load-use cycles,
//   miss_cnt                     branch flushes, miss entries
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int REG_AW   = 5,
   parameter int MISS_LAT = 4,
   parameter int CNT_W    = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] Rs1_D,
   input  logic [REG_AW-1:0] Rs2_D,
   input  logic [REG_AW-1:0] Rs1_E,
   input  logic [REG_AW-1:0] Rs2_E,
   input  logic [REG_AW-1:0] Rd_E,
   input  logic [REG_AW-1:0] Rd_M,
   input  logic [REG_AW-1:0] Rd_W,
   input  logic              RegWrite_M,
   input  logic              RegWrite_W,
   input  logic              MemRead_E,
   input  logic              branch,
   input  logic              mem_access_M,
   input  logic              hit,
   input  logic              refill_done,
   output logic [1:0]        forwardA_E,
   output logic [1:0]        forwardB_E,
   output logic              stall_F,
   output logic              stall_D,
   output logic              flush_D,
   output logic              flush_E,
   output logic              freeze,
   output logic              miss_busy
`ifdef HAZARD_PERF_EN
  ,output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt,
   output logic [CNT_W-1:0]  miss_cnt
`endif
);

   // Reject illegal configurations at elaboration time
   if ((MISS_LAT < 1) || (MISS_LAT > 255) || (CNT_W < 1) || (REG_AW < 1)) begin : g_bad_param
      $error("pipeline_hazard_ctrl: illegal parameter value");
   end

   logic load_use;
`ifdef HAZARD_PERF_EN
   logic miss_start;
`endif

   // Forwarding: the MEM-stage result is newer than WB, so it wins. x0 is
   // hard-wired zero and must never be forwarded even if "written".
   always_comb begin
      forwardA_E = FWD_REG;
      if (RegWrite_M && (Rd_M != '0) && (Rd_M == Rs1_E))
         forwardA_E = FWD_MEM;
      else if (RegWrite_W && (Rd_W != '0) && (Rd_W == Rs1_E))
         forwardA_E = FWD_WB;

      forwardB_E = FWD_REG;
      if (RegWrite_M && (Rd_M != '0) && (Rd_M == Rs2_E))
         forwardB_E = FWD_MEM;
      else if (RegWrite_W && (Rd_W != '0) && (Rd_W == Rs2_E))
         forwardB_E = FWD_WB;
   end

   // Load-use holds F/D and bubbles EX. A taken branch discards the
   // dependent instruction anyway, so it overrides the stall. A freeze
   // or held reset silences all of these.
   always_comb begin
      load_use = MemRead_E && (Rd_E != '0) && ((Rd_E == Rs1_D) || (Rd_E == Rs2_D));
      stall_F  = rst && !freeze && load_use && !branch;
      stall_D  = rst && !freeze && load_use && !branch;
      flush_D  = rst && !freeze && branch;
      flush_E  = rst && !freeze && (branch || load_use);
   end

   miss_stall_fsm #(
      .MISS_LAT (MISS_LAT)
   ) u_miss_stall_fsm (
      .clk         (clk),
      .rst         (rst),
      .mem_access  (mem_access_M),
      .hit         (hit),
      .refill_done (refill_done),
      .freeze      (freeze),
      .miss_busy   (miss_busy)
`ifdef HAZARD_PERF_EN
     ,.miss_start  (miss_start)
`endif
   );

`ifdef HAZARD_PERF_EN
   // Saturating event counters; they count the effective (post-priority,
   // post-freeze) events so a deferred branch is counted once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
         miss_cnt  <= '0;
      end else begin
         if (stall_F && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
         if (flush_D && (flush_cnt != '1))
            flush_cnt <= flush_cnt + 1'b1;
         if (miss_start && (miss_cnt != '1))
            miss_cnt <= miss_cnt + 1'b1;
      end
   end
`endif

endmodule
